// File: rtl/rw_sequencer.sv
// rw_sequencer
// Sequences an 8-byte memory read or write as two USB-style sub-transactions:
// an address OUT (mempage on ADDR_ENDP) followed by a data OUT (write) or a
// data IN (read) on DATA_ENDP. Each phase has its own watchdog.
//
// Ports
//   clock, reset_n                : clock, asynchronous active-low reset
//   read_start, write_start       : one-cycle task requests (read wins a tie)
//   mempage, data_in              : task operands, captured on accept
//   busy, finished                : task in progress / one-cycle end pulse
//   read_success, write_success   : outcome, meaningful while finished=1
//   data_out                      : payload of the last successful read
//   out_start/out_endp/out_data   : request to the OUT-transaction block
//   out_done/out_success/out_failure : OUT completion status
//   in_start/in_endp              : request to the IN-transaction block
//   in_done/in_success/in_failure/in_data : IN completion status and data
module rw_sequencer #(
    parameter logic [3:0]  ADDR_ENDP   = 4'd4,
    parameter logic [3:0]  DATA_ENDP   = 4'd8,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        read_start,
    input  logic        write_start,
    input  logic [15:0] mempage,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        finished,
    output logic        read_success,
    output logic        write_success,
    output logic [63:0] data_out,
    output logic        out_start,
    output logic [3:0]  out_endp,
    output logic [63:0] out_data,
    input  logic        out_done,
    input  logic        out_success,
    input  logic        out_failure,
    output logic        in_start,
    output logic [3:0]  in_endp,
    input  logic        in_done,
    input  logic        in_success,
    input  logic        in_failure,
    input  logic [63:0] in_data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR_OUT = 3'd1,
        S_DATA_OUT = 3'd2,
        S_DATA_IN  = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        finished_q, finished_d;
    logic        rd_ok_q, rd_ok_d;
    logic        wr_ok_q, wr_ok_d;
    logic [63:0] data_out_q, data_out_d;
    logic        out_start_q, out_start_d;
    logic [3:0]  out_endp_q, out_endp_d;
    logic [63:0] out_data_q, out_data_d;
    logic        in_start_q, in_start_d;
    logic [3:0]  in_endp_q, in_endp_d;
    logic        is_write_q, is_write_d;
    logic [63:0] wdata_q, wdata_d;
    logic [31:0] wd_q, wd_d;

    logic        out_good_s;
    logic        in_good_s;
    logic        timeout_s;
    logic [31:0] wd_inc_s;
    logic        enter_finish_s;

    // A completion is good only with success set and failure clear.
    assign out_good_s = out_done & out_success & ~out_failure;
    assign in_good_s  = in_done & in_success & ~in_failure;
    assign timeout_s  = (wd_q == (TIMEOUT_CYC - 32'd1));
    assign wd_inc_s   = (wd_q == 32'hFFFF_FFFF) ? wd_q : (wd_q + 32'd1);

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        finished_d     = 1'b0;
        rd_ok_d        = 1'b0;
        wr_ok_d        = 1'b0;
        data_out_d     = data_out_q;
        out_start_d    = 1'b0;
        out_endp_d     = out_endp_q;
        out_data_d     = out_data_q;
        in_start_d     = 1'b0;
        in_endp_d      = in_endp_q;
        is_write_d     = is_write_q;
        wdata_d        = wdata_q;
        wd_d           = wd_inc_s;
        enter_finish_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                wd_d   = 32'd0;
                busy_d = 1'b0;
                if (read_start || write_start) begin
                    busy_d      = 1'b1;
                    is_write_d  = ~read_start;
                    wdata_d     = data_in;
                    state_d     = S_ADDR_OUT;
                    out_start_d = 1'b1;
                    out_endp_d  = ADDR_ENDP;
                    out_data_d  = {48'd0, mempage};
                end else begin
                    state_d = S_IDLE;
                end
            end
            // The start cycle of each phase (start flop high) ignores done.
            S_ADDR_OUT: begin
                if (!out_start_q && out_done) begin
                    if (out_good_s) begin
                        wd_d = 32'd0;
                        if (is_write_q) begin
                            state_d     = S_DATA_OUT;
                            out_start_d = 1'b1;
                            out_endp_d  = DATA_ENDP;
                            out_data_d  = wdata_q;
                        end else begin
                            state_d    = S_DATA_IN;
                            in_start_d = 1'b1;
                            in_endp_d  = DATA_ENDP;
                            out_endp_d = 4'd0;
                            out_data_d = 64'd0;
                        end
                    end else begin
                        enter_finish_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    enter_finish_s = 1'b1;
                end else begin
                    state_d = S_ADDR_OUT;
                end
            end
            S_DATA_OUT: begin
                if (!out_start_q && out_done) begin
                    enter_finish_s = 1'b1;
                    wr_ok_d        = out_good_s;
                end else if (timeout_s) begin
                    enter_finish_s = 1'b1;
                end else begin
                    state_d = S_DATA_OUT;
                end
            end
            S_DATA_IN: begin
                if (!in_start_q && in_done) begin
                    enter_finish_s = 1'b1;
                    if (in_good_s) begin
                        rd_ok_d    = 1'b1;
                        data_out_d = in_data;
                    end else begin
                        rd_ok_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    enter_finish_s = 1'b1;
                end else begin
                    state_d = S_DATA_IN;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                wd_d    = 32'd0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                wd_d    = 32'd0;
            end
        endcase

        // Common exit path: busy stays high through the finished cycle.
        if (enter_finish_s) begin
            state_d    = S_FINISH;
            finished_d = 1'b1;
            wd_d       = 32'd0;
            out_endp_d = 4'd0;
            out_data_d = 64'd0;
            in_endp_d  = 4'd0;
        end else begin
            finished_d = 1'b0;
        end
    end

    // State, output and operand registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            rd_ok_q     <= 1'b0;
            wr_ok_q     <= 1'b0;
            data_out_q  <= 64'd0;
            out_start_q <= 1'b0;
            out_endp_q  <= 4'd0;
            out_data_q  <= 64'd0;
            in_start_q  <= 1'b0;
            in_endp_q   <= 4'd0;
            is_write_q  <= 1'b0;
            wdata_q     <= 64'd0;
            wd_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            rd_ok_q     <= rd_ok_d;
            wr_ok_q     <= wr_ok_d;
            data_out_q  <= data_out_d;
            out_start_q <= out_start_d;
            out_endp_q  <= out_endp_d;
            out_data_q  <= out_data_d;
            in_start_q  <= in_start_d;
            in_endp_q   <= in_endp_d;
            is_write_q  <= is_write_d;
            wdata_q     <= wdata_d;
            wd_q        <= wd_d;
        end
    end

    assign busy          = busy_q;
    assign finished      = finished_q;
    assign read_success  = rd_ok_q;
    assign write_success = wr_ok_q;
    assign data_out      = data_out_q;
    assign out_start     = out_start_q;
    assign out_endp      = out_endp_q;
    assign out_data      = out_data_q;
    assign in_start      = in_start_q;
    assign in_endp       = in_endp_q;

endmodule

// File: tb/tb_rw_sequencer.sv
// Testbench for rw_sequencer: a directed table, randomized tasks checked
// against a task-level outcome model, and a mid-task reset sequence.
module tb_rw_sequencer;

    localparam int          T     = 16;
    localparam int          NONE  = 99;   // phase delay meaning "never answer"
    localparam logic [3:0]  AEP   = 4'd4;
    localparam logic [3:0]  DEP   = 4'd8;

    logic        clock, reset_n, read_start, write_start;
    logic [15:0] mempage;
    logic [63:0] data_in;
    logic        busy, finished, read_success, write_success;
    logic [63:0] data_out;
    logic        out_start;
    logic [3:0]  out_endp;
    logic [63:0] out_data;
    logic        out_done, out_success, out_failure;
    logic        in_start;
    logic [3:0]  in_endp;
    logic        in_done, in_success, in_failure;
    logic [63:0] in_data;

    rw_sequencer #(
        .ADDR_ENDP  (AEP),
        .DATA_ENDP  (DEP),
        .TIMEOUT_CYC(32'd16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .read_start(read_start), .write_start(write_start),
        .mempage(mempage), .data_in(data_in),
        .busy(busy), .finished(finished),
        .read_success(read_success), .write_success(write_success),
        .data_out(data_out),
        .out_start(out_start), .out_endp(out_endp), .out_data(out_data),
        .out_done(out_done), .out_success(out_success), .out_failure(out_failure),
        .in_start(in_start), .in_endp(in_endp),
        .in_done(in_done), .in_success(in_success), .in_failure(in_failure),
        .in_data(in_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] page;
        logic [63:0] wdata;
        int          d1;
        logic        s1;
        logic        f1;
        int          d2;
        logic        s2;
        logic        f2;
        logic [63:0] indata;
        logic        poke;
        logic        exp_rs;
        logic        exp_ws;
        logic [63:0] exp_dout;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] model_dout;

    // Event monitor: counts start pulses and captures finished-cycle outputs.
    int cyc = 0, os_cnt = 0, is_cnt = 0, fin_cnt = 0, dual_err = 0;
    int os_cyc = 0, is_cyc = 0, fin_cyc = 0;
    logic [3:0]  os_endp, is_endp;
    logic [63:0] os_data, fin_dout;
    logic        fin_rs, fin_ws;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (out_start) begin
            os_cnt  <= os_cnt + 1;
            os_cyc  <= cyc;
            os_endp <= out_endp;
            os_data <= out_data;
        end
        if (in_start) begin
            is_cnt  <= is_cnt + 1;
            is_cyc  <= cyc;
            is_endp <= in_endp;
        end
        if (out_start && in_start) dual_err <= dual_err + 1;
        if (finished) begin
            fin_cnt  <= fin_cnt + 1;
            fin_cyc  <= cyc;
            fin_rs   <= read_success;
            fin_ws   <= write_success;
            fin_dout <= data_out;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outcome model: a phase succeeds if answered within the watchdog window
    // with success set and failure clear; it lasts delay+1 cycles, or T.
    function automatic logic phase_good(input int d, input logic s, input logic f);
        return (d <= T - 1) && s && !f;
    endfunction

    function automatic int phase_len(input int d);
        return (d > T - 1) ? T : d + 1;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] pg,
                                input logic [63:0] wd, input int d1, input logic s1,
                                input logic f1, input int d2, input logic s2,
                                input logic f2, input logic [63:0] idat, input logic poke,
                                input logic ers, input logic ews, input logic [63:0] edo);
        vec_t v;
        v.rd = rd; v.wr = wr; v.page = pg; v.wdata = wd;
        v.d1 = d1; v.s1 = s1; v.f1 = f1; v.d2 = d2; v.s2 = s2; v.f2 = f2;
        v.indata = idat; v.poke = poke;
        v.exp_rs = ers; v.exp_ws = ews; v.exp_dout = edo;
        return v;
    endfunction

    // Answer the current phase d cycles after its start cycle.
    task automatic send_done(input logic is_in, input int d, input logic s, input logic f,
                             input logic [63:0] idata, input logic poke,
                             input logic [3:0] exp_endp, input logic [63:0] exp_data);
        if (d <= T - 1) begin
            for (int i = 0; i < d; i++) begin
                @(negedge clock); #1;
                write_start = poke && (i == 0);
            end
            write_start = 1'b0;
            if (!is_in) begin
                check("out_endp_hold", 64'(out_endp), 64'(exp_endp));
                check("out_data_hold", out_data, exp_data);
                out_done = 1'b1; out_success = s; out_failure = f;
            end else begin
                in_done = 1'b1; in_success = s; in_failure = f; in_data = idata;
            end
            @(negedge clock); #1;
            out_done = 1'b0; out_success = 1'b0; out_failure = 1'b0;
            in_done  = 1'b0; in_success  = 1'b0; in_failure  = 1'b0;
            in_data  = {$urandom, $urandom};
        end else begin
            write_start = 1'b0;
        end
    endtask

    task automatic do_task(input vec_t v);
        logic g1;
        int   exp_lat, os0, is0, fin0, c0, budget;
        g1      = phase_good(v.d1, v.s1, v.f1);
        exp_lat = phase_len(v.d1) + (g1 ? phase_len(v.d2) : 0);
        os0 = os_cnt; is0 = is_cnt; fin0 = fin_cnt;

        read_start = v.rd; write_start = v.wr; mempage = v.page; data_in = v.wdata;
        @(negedge clock); #1;
        read_start = 1'b0; write_start = 1'b0;
        mempage = 16'($urandom); data_in = {$urandom, $urandom};
        budget = 5;
        while (os_cnt == os0 && budget > 0) begin @(negedge clock); #1; budget--; end
        check("addr_start_seen", 64'(os_cnt - os0), 64'(1));
        c0 = os_cyc;
        check("addr_endp", 64'(os_endp), 64'(AEP));
        check("addr_data", os_data, {48'd0, v.page});
        check("busy_in_task", 64'(busy), 64'(1));
        send_done(1'b0, v.d1, v.s1, v.f1, 64'd0, v.poke, AEP, {48'd0, v.page});

        if (g1) begin
            budget = 5;
            if (v.rd) begin
                while (is_cnt == is0 && budget > 0) begin @(negedge clock); #1; budget--; end
                check("data_in_start_seen", 64'(is_cnt - is0), 64'(1));
                check("in_endp", 64'(is_endp), 64'(DEP));
                send_done(1'b1, v.d2, v.s2, v.f2, v.indata, 1'b0, 4'd0, 64'd0);
            end else begin
                while (os_cnt == os0 + 1 && budget > 0) begin @(negedge clock); #1; budget--; end
                check("data_out_start_seen", 64'(os_cnt - os0), 64'(2));
                check("data_endp", 64'(os_endp), 64'(DEP));
                check("data_payload", os_data, v.wdata);
                send_done(1'b0, v.d2, v.s2, v.f2, 64'd0, 1'b0, DEP, v.wdata);
            end
        end

        budget = 60;
        while (fin_cnt == fin0 && budget > 0) begin @(negedge clock); #1; budget--; end
        check("finished_seen", 64'(fin_cnt - fin0), 64'(1));
        check("latency", 64'(fin_cyc - c0), 64'(exp_lat));
        check("read_success", 64'(fin_rs), 64'(v.exp_rs));
        check("write_success", 64'(fin_ws), 64'(v.exp_ws));
        check("data_out", fin_dout, v.exp_dout);
        repeat (2) begin @(negedge clock); #1; end
        check("idle_after", 64'({busy, finished, read_success, write_success}), 64'd0);
        check("out_start_count", 64'(os_cnt - os0), 64'((g1 && !v.rd) ? 2 : 1));
        check("in_start_count", 64'(is_cnt - is0), 64'((g1 && v.rd) ? 1 : 0));
    endtask

    task automatic reset_mid_read();
        int os0, is0, fin0, budget;
        os0 = os_cnt; is0 = is_cnt;
        read_start = 1'b1; mempage = 16'h7777;
        @(negedge clock); #1;
        read_start = 1'b0;
        budget = 5;
        while (os_cnt == os0 && budget > 0) begin @(negedge clock); #1; budget--; end
        send_done(1'b0, 2, 1'b1, 1'b0, 64'd0, 1'b0, AEP, {48'd0, 16'h7777});
        budget = 5;
        while (is_cnt == is0 && budget > 0) begin @(negedge clock); #1; budget--; end
        check("rst_pre_in_start", 64'(is_cnt - is0), 64'(1));
        @(negedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("midreset_ctrl", 64'({busy, finished, read_success, write_success,
                                    out_start, in_start, out_endp, in_endp}), 64'd0);
        check("midreset_out_data", out_data, 64'd0);
        check("midreset_data_out", data_out, 64'd0);
        repeat (2) begin @(negedge clock); #1; end
        reset_n = 1'b1;
        model_dout = 64'd0;
        os0 = os_cnt; is0 = is_cnt; fin0 = fin_cnt;
        @(negedge clock); #1;
        in_done = 1'b1; in_success = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock); #1;
        in_done = 1'b0; in_success = 1'b0;
        repeat (3) begin @(negedge clock); #1; end
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_data_out", data_out, 64'd0);
        check("stray_no_finish", 64'(fin_cnt - fin0), 64'd0);
        check("stray_no_start", 64'((os_cnt - os0) + (is_cnt - is0)), 64'd0);
    endtask

    vec_t tbl[11];
    localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;

    initial begin
        reset_n = 1'b0; read_start = 1'b0; write_start = 1'b0;
        mempage = 16'd0; data_in = 64'd0;
        out_done = 1'b0; out_success = 1'b0; out_failure = 1'b0;
        in_done = 1'b0; in_success = 1'b0; in_failure = 1'b0; in_data = 64'd0;

        tbl[0]  = mk(1'b1, 1'b0, 16'h1234, 64'd0, 10, 1'b1, 1'b0, 3, 1'b1, 1'b0,
                     D1, 1'b0, 1'b1, 1'b0, D1);
        tbl[1]  = mk(1'b0, 1'b1, 16'h0042, 64'h01020304_05060708, 2, 1'b1, 1'b0, 4, 1'b1, 1'b0,
                     64'd0, 1'b0, 1'b0, 1'b1, D1);
        tbl[2]  = mk(1'b1, 1'b0, 16'h00AA, 64'd0, 3, 1'b0, 1'b1, 1, 1'b1, 1'b0,
                     64'd1, 1'b0, 1'b0, 1'b0, D1);
        tbl[3]  = mk(1'b1, 1'b0, 16'h00BB, 64'd0, 1, 1'b1, 1'b1, 1, 1'b1, 1'b0,
                     64'd2, 1'b0, 1'b0, 1'b0, D1);
        tbl[4]  = mk(1'b0, 1'b1, 16'h00CC, 64'h1111, 1, 1'b1, 1'b0, 2, 1'b1, 1'b1,
                     64'd0, 1'b0, 1'b0, 1'b0, D1);
        tbl[5]  = mk(1'b1, 1'b0, 16'h00DD, 64'd0, 5, 1'b1, 1'b0, 5, 1'b0, 1'b1,
                     64'hBAD, 1'b0, 1'b0, 1'b0, D1);
        tbl[6]  = mk(1'b0, 1'b1, 16'h00EE, 64'h2222, NONE, 1'b1, 1'b0, 1, 1'b1, 1'b0,
                     64'd0, 1'b0, 1'b0, 1'b0, D1);
        tbl[7]  = mk(1'b1, 1'b0, 16'h00FF, 64'd0, 1, 1'b1, 1'b0, NONE, 1'b1, 1'b0,
                     64'd3, 1'b0, 1'b0, 1'b0, D1);
        tbl[8]  = mk(1'b0, 1'b1, 16'hFFFF, 64'hFFFF0000_FFFF0000, 15, 1'b1, 1'b0, 15, 1'b1, 1'b0,
                     64'd0, 1'b0, 1'b0, 1'b1, D1);
        tbl[9]  = mk(1'b1, 1'b1, 16'h5555, 64'h9999, 4, 1'b1, 1'b0, 6, 1'b1, 1'b0,
                     64'h11112222_33334444, 1'b1, 1'b1, 1'b0, 64'h11112222_33334444);
        tbl[10] = mk(1'b1, 1'b0, 16'h0001, 64'd0, 1, 1'b1, 1'b0, 1, 1'b1, 1'b0,
                     64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1, 1'b0, 64'hA5A5A5A5_5A5A5A5A);

        repeat (3) begin @(negedge clock); #1; end
        check("reset_ctrl", 64'({busy, finished, read_success, write_success,
                                 out_start, in_start, out_endp, in_endp}), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_data_out", data_out, 64'd0);
        reset_n = 1'b1;
        repeat (2) begin @(negedge clock); #1; end

        for (int i = 0; i < 11; i++) do_task(tbl[i]);
        model_dout = tbl[10].exp_dout;

        for (int i = 0; i < 24; i++) begin
            vec_t v;
            int   k;
            k = $urandom_range(0, 2);
            v.rd = (k != 1); v.wr = (k != 0);
            v.page = 16'($urandom); v.wdata = {$urandom, $urandom};
            v.d1 = ($urandom_range(0, 9) == 0) ? NONE : $urandom_range(1, 15);
            k = $urandom_range(0, 3);
            v.s1 = (k != 2); v.f1 = (k >= 2);
            v.d2 = ($urandom_range(0, 9) == 0) ? NONE : $urandom_range(1, 15);
            k = $urandom_range(0, 3);
            v.s2 = (k != 2); v.f2 = (k >= 2);
            v.indata = {$urandom, $urandom};
            v.poke = (v.d1 >= 2 && v.d1 <= 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.exp_rs = v.rd && phase_good(v.d1, v.s1, v.f1) && phase_good(v.d2, v.s2, v.f2);
            v.exp_ws = !v.rd && phase_good(v.d1, v.s1, v.f1) && phase_good(v.d2, v.s2, v.f2);
            if (v.exp_rs) model_dout = v.indata;
            v.exp_dout = model_dout;
            do_task(v);
        end

        reset_mid_read();
        do_task(mk(1'b1, 1'b0, 16'h0BEE, 64'd0, 3, 1'b1, 1'b0, 2, 1'b1, 1'b0,
                   64'h01234567_89ABCDEF, 1'b0, 1'b1, 1'b0, 64'h01234567_89ABCDEF));

        check("single_start", 64'(dual_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/rw_sequencer.md
RW_SEQUENCER -- requirements
Module: rw_sequencer

Interface
REQ-001 Parameter ADDR_ENDP, default 4'd4, endpoint used for the address OUT transaction.
REQ-002 Parameter DATA_ENDP, default 4'd8, endpoint used for the data OUT/IN transaction.
REQ-003 Parameter TIMEOUT_CYC, default 32'd100000, per-phase watchdog limit in clock cycles.
REQ-004 clock  input  1  single clock, all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 read_start  input  1  one-cycle request for an 8-byte read at mempage.
REQ-007 write_start  input  1  one-cycle request for an 8-byte write of data_in at mempage.
REQ-008 mempage  input  16  target memory page, sampled on accept.
REQ-009 data_in  input  64  write payload, sampled on accept.
REQ-010 busy  output  1  high from accept through the finished cycle.
REQ-011 finished  output  1  one-cycle pulse when a task ends.
REQ-012 read_success / write_success  output  1 each  outcome, valid only while finished=1.
REQ-013 data_out  output  64  data from the last successful read.
REQ-014 out_start  output  1  one-cycle start pulse to the OUT-transaction block.
REQ-015 out_endp / out_data  output  4 / 64  endpoint and payload for the OUT transaction, held stable while that phase is active.
REQ-016 out_done, out_success, out_failure  input  1 each  OUT-transaction completion status.
REQ-017 in_start  output  1  one-cycle start pulse to the IN-transaction block.
REQ-018 in_endp  output  4  endpoint for the IN transaction.
REQ-019 in_done, in_success, in_failure  input  1 each  IN-transaction completion status.
REQ-020 in_data  input  64  received IN data, valid in the in_done cycle.

Function
REQ-021 States: IDLE, ADDR_OUT, DATA_OUT, DATA_IN, FINISH. All outputs are registered.
REQ-022 Accept in IDLE only. Set busy=1, latch cmd/mempage/data_in, move to ADDR_OUT.
REQ-023 If read_start and write_start are high in the same IDLE cycle, read wins. Starts while busy=1 are ignored.
REQ-024 On entry to each phase, assert the matching start (out_start or in_start) for exactly the first cycle, and clear the watchdog count to 0.
REQ-025 ADDR_OUT: out_endp=ADDR_ENDP, out_data={48'd0, mempage}.
REQ-026 On out_done with out_success=1 and out_failure=0 in ADDR_OUT, go to DATA_IN for a read or DATA_OUT for a write.
REQ-027 DATA_OUT: out_endp=DATA_ENDP, out_data=latched data_in. On a good out_done, go to FINISH with write_success=1.
REQ-028 DATA_IN: in_endp=DATA_ENDP. On a good in_done, load data_out<=in_data and go to FINISH with read_success=1.
REQ-029 A done with the failure bit set, or with both success and failure set, is a failure. Go to FINISH with both success bits 0.
REQ-030 out_done/out_success/out_failure are ignored outside ADDR_OUT/DATA_OUT. in_done/in_success/in_failure are ignored outside DATA_IN.
REQ-031 Done inputs are ignored in the phase's entry (start) cycle.
REQ-032 Watchdog: 32-bit count, increments each cycle in a phase and saturates. When it equals TIMEOUT_CYC-1 with no done, the task fails (REQ-029). A done in that same cycle takes priority.
REQ-033 FINISH lasts one cycle: finished=1, busy=1. Then IDLE, busy=0, success bits cleared.
REQ-034 data_out changes only per REQ-028 or reset. It is held on failure and across write tasks.
REQ-035 Only one of out_start / in_start is ever high, and at most one sub-transaction is outstanding.

Reset
REQ-036 reset_n=0 forces IDLE at once, mid-task included.
REQ-037 Under reset, all outputs are 0: busy, finished, both success bits, out_start, in_start, out_endp, out_data, in_endp, data_out. The watchdog and latches are also 0.
REQ-038 After reset_n rises, the next accepted start begins a fresh task. Late done pulses from an aborted sub-transaction are ignored per REQ-030.

Verification
REQ-039 Read: read_start, mempage=16'h1234, out_done+out_success after 10 cycles, then in_done+in_success with in_data=64'hDEADBEEF_CAFEF00D. Required: out_data=64'h1234, out_endp=4, in_endp=8, finished pulse with read_success=1, data_out=64'hDEADBEEF_CAFEF00D.
REQ-040 Write: write_start, mempage=16'h0042, data_in=64'h0102030405060708, two good out_done. Required: second out_data=64'h0102030405060708 on endpoint 8, write_success=1, in_start never high.
REQ-041 Failure: read with out_failure=1 on the address phase. Required: no in_start, finished with both success bits 0, data_out unchanged.
REQ-042 Timeout: TIMEOUT_CYC=16, write, no out_done. Required: finished exactly 16 cycles after out_start, write_success=0.
REQ-043 Collision and busy: read_start and write_start together, then write_start while busy. Required: a read is performed and the second request is dropped.
REQ-044 Reset mid-DATA_IN, then a stray in_done after release. Required: all outputs 0 and the FSM stays in IDLE.
